tt_sweep_ctrl: RTL
==================

TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 0: number of wait cycles between driving a pattern and sampling y0 (legal range 0..7).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request a sweep; accepted only in IDLE.
REQ-005 SHALL have port exp_tt  input  16  expected truth table, captured on start acceptance.
REQ-006 SHALL have ports x0, x1, x2, x3  output  1 each  pattern driven to the external 4-input function under evaluation.
REQ-007 SHALL have port y0  input  1  response of the external function.
REQ-008 SHALL have port tt  output  16  collected truth table; bit i = y0 for pattern i, where i = {x3,x2,x1,x0}.
REQ-009 SHALL have port ones  output  5  population count of tt (0..16).
REQ-010 SHALL have port match  output  1  high when tt equals the captured exp_tt.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port busy  output  1  high in RUN and DONE.

Function
REQ-014 SHALL implement states IDLE, RUN and DONE, all held in registers.
REQ-015 IDLE: start=1 at an edge SHALL move to RUN, clear tt, ones and the wait counter, set idx=0, and capture exp_tt.
REQ-016 x3..x0 SHALL be registered copies of idx in RUN, and 0 in IDLE and DONE.
REQ-017 RUN, each cycle: if wcnt==SETTLE, SHALL write tt[idx]<=y0, add y0 to ones, clear wcnt and increment idx; otherwise SHALL increment wcnt.
REQ-018 The sample of idx=15 SHALL move to DONE; idx SHALL not wrap.
REQ-019 RUN SHALL last exactly 16*(SETTLE+1) cycles; out_valid SHALL rise the cycle after the last sample.
REQ-020 y0 SHALL be sampled only on sample cycles and ignored otherwise.
REQ-021 DONE: out_valid=1; tt, ones and match SHALL be held stable until out_valid&out_ready, which SHALL return to IDLE the next cycle.
REQ-022 start SHALL be ignored in RUN and DONE, including the handshake cycle; a new sweep needs start in IDLE.
REQ-023 match SHALL be valid only while out_valid=1 and SHALL be 0 otherwise.
REQ-024 ones SHALL equal the popcount of tt at all times; 5-bit width SHALL hold the value 16 without overflow.
REQ-025 tt and ones SHALL keep the last result in IDLE until the next start acceptance.

Reset
REQ-026 rst_n=0 at an edge SHALL force IDLE; tt=0, ones=0, match=0, out_valid=0, busy=0, x3..x0=0, idx=0, wcnt=0, captured exp_tt=0.
REQ-027 Reset SHALL take priority over start and the handshake, and SHALL abort RUN or DONE with no partial result presented.
REQ-028 Once rst_n=1, start SHALL be accepted at the first edge.

Verification
REQ-029 SETTLE=0, y0=x0, exp_tt=0xAAAA, out_ready=1 -> out_valid 16 cycles after start, tt=0xAAAA, ones=8, match=1.
REQ-030 SETTLE=2, y0=x0^x1^x2^x3, exp_tt=0x0000 -> out_valid after 48 cycles, tt=0x6996, ones=8, match=0.
REQ-031 y0 tied 1, out_ready held 0 for 10 cycles -> tt=0xFFFF, ones=16, out_valid and outputs stable for all 10 cycles, IDLE one cycle after out_ready=1.
REQ-032 start pulsed during RUN and on the handshake cycle -> no restart; exactly one result; busy=0 after the handshake.
REQ-033 rst_n=0 for one cycle at idx=7 -> next cycle all outputs 0, state IDLE; a new start yields a correct full 16-pattern sweep.
REQ-034 y0 toggled on non-sample cycles with SETTLE=3 -> tt reflects only the values present on sample cycles.

Source files
------------

// File: rtl/tt_sweep_ctrl_if.sv
// tt_sweep_ctrl_if
// Groups the sweep request, pattern drive, response and result handshake
// signals of tt_sweep_ctrl.
//   start      request a sweep (accepted only while idle)
//   exp_tt     expected truth table, captured when a sweep is accepted
//   x0..x3     pattern driven to the external 4-input function
//   y0         response of the external function
//   tt         collected truth table, bit i = response to pattern i
//   ones       population count of tt
//   match      tt equals the captured expected table (only while out_valid)
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   busy       sweep in progress or result pending
// Modport slave is the controller side, master is the requester side.
interface tt_sweep_ctrl_if;
  logic        start;
  logic [15:0] exp_tt;
  logic        x0;
  logic        x1;
  logic        x2;
  logic        x3;
  logic        y0;
  logic [15:0] tt;
  logic [4:0]  ones;
  logic        match;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  modport master (
    output start, exp_tt, y0, out_ready,
    input  x0, x1, x2, x3, tt, ones, match, out_valid, busy
  );

  modport slave (
    input  start, exp_tt, y0, out_ready,
    output x0, x1, x2, x3, tt, ones, match, out_valid, busy
  );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl
// Walks all 16 input patterns of an external 4-input combinational function,
// waits SETTLE cycles after each pattern is driven, samples the response and
// assembles the truth table, its popcount and a compare against an expected
// table. The result is offered with a valid/ready handshake.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    tt_sweep_ctrl_if.slave (start/exp_tt in, x0..x3 out, y0 in,
//          tt/ones/match/out_valid/busy out, out_ready in)
module tt_sweep_ctrl #(
  parameter int SETTLE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  tt_sweep_ctrl_if.slave  bus
);

  localparam logic [2:0] SETTLE_C = 3'(SETTLE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [3:0]  idx;
  logic [2:0]  wcnt;
  logic [15:0] exp_q;
  logic [15:0] tt_q;
  logic [4:0]  ones_q;
  logic        match_q;
  logic        valid_q;
  logic        busy_q;
  logic [3:0]  x_q;

  logic        sample;
  logic [15:0] tt_final;

  // The current pattern has settled long enough; y0 is taken this cycle.
  assign sample = (wcnt == SETTLE_C);

  // Complete table as it will look after the pattern-15 sample, so the
  // compare result can be registered together with the last bit.
  assign tt_final = {bus.y0, tt_q[14:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= 4'd0;
      wcnt    <= 3'd0;
      exp_q   <= 16'd0;
      tt_q    <= 16'd0;
      ones_q  <= 5'd0;
      match_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      x_q     <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            tt_q   <= 16'd0;
            ones_q <= 5'd0;
            wcnt   <= 3'd0;
            idx    <= 4'd0;
            x_q    <= 4'd0;
            exp_q  <= bus.exp_tt;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (sample) begin
            tt_q[idx] <= bus.y0;
            ones_q    <= ones_q + {4'd0, bus.y0};
            wcnt      <= 3'd0;
            if (idx == 4'd15) begin
              // Last pattern: idx stays at 15, drive returns to 0.
              state   <= DONE;
              x_q     <= 4'd0;
              valid_q <= 1'b1;
              match_q <= (tt_final == exp_q);
            end else begin
              // x follows idx so the next pattern is on the pins while
              // its settle window runs.
              idx <= idx + 4'd1;
              x_q <= idx + 4'd1;
            end
          end else begin
            wcnt <= wcnt + 3'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x0        = x_q[0];
  assign bus.x1        = x_q[1];
  assign bus.x2        = x_q[2];
  assign bus.x3        = x_q[3];
  assign bus.tt        = tt_q;
  assign bus.ones      = ones_q;
  assign bus.match     = match_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;

endmodule
